spi_reg_ctrl: RTL and testbench
===============================

Name: spi_reg_ctrl

Overview:
- Command/register controller between the spi_slave byte engine and design consumers such as the seven_seg digit inputs.
- Decodes SPI frames delimited by slave-select into read/write accesses on an internal 8-bit register bank.
- Supplies the next transmit byte to spi_slave and exposes the register bank as a flat bus.
- Sits in the clk domain; spi_slave's trigger outputs have already been brought into clk.

Parameters:
- NUM_REGS, 8, number of 8-bit registers; legal range 2..128.
- ADDR_W, 3, address width; must satisfy 2**ADDR_W >= NUM_REGS.
- SYNC_BYTE, 8'hA5, byte returned during the command byte of every frame.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset.
- ss  input  1  raw SPI slave-select, active-low, asynchronous to clk.
- rx_byte  input  8  byte received by spi_slave; valid when rx_valid=1.
- rx_valid  input  1  one-cycle pulse: spi_slave finished receiving a byte.
- tx_req  input  1  one-cycle pulse: spi_slave latches tx_byte for the next byte.
- tx_byte  output  8  registered byte offered to spi_slave.
- regs_flat  output  NUM_REGS*8  register bank; reg i occupies bits [8i+7:8i].
- wr_strobe  output  1  one-cycle pulse on each register write.
- wr_addr  output  ADDR_W  address of the current/last write.
- err_cnt  output  8  saturating count of frames with an illegal address.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all regs 0, tx_byte=SYNC_BYTE, wr_strobe=0, wr_addr=0, err_cnt=0, state=IDLE.
- ss synchronisation:
  - ss passes through a 2-flop synchroniser (flops reset to 1); ss_s is the synchronised value.
  - Frame start = ss_s falling edge; frame end = ss_s rising edge.
- State machine: IDLE, CMD, DATA, DROP.
  - IDLE: rx_valid ignored. On ss_s falling edge -> CMD, tx_byte<=SYNC_BYTE.
  - CMD: first rx_valid is the command byte: bit7=1 write, bit7=0 read, bits[6:0]=addr.
    - addr >= NUM_REGS -> DROP, err_cnt+1 (saturates at 255).
    - otherwise -> DATA with ptr<=addr; for a read, tx_byte<=reg[addr] in the same cycle.
  - DATA, write: each rx_valid writes reg[ptr]<=rx_byte and pulses wr_strobe with wr_addr=ptr, registered one cycle after rx_valid.
  - DATA, read: each rx_valid leaves registers unchanged; tx_byte<=reg[next ptr].
  - DROP: all rx_valid ignored; tx_byte=8'h00.
  - Any state except IDLE: ss_s rising edge -> IDLE, tx_byte<=SYNC_BYTE.
- tx_req: does not change state; tx_byte must already be stable when it arrives. tx_byte only changes on rx_valid or on a frame edge.
- Simultaneous rx_valid and ss_s rising edge: the byte is fully processed (write or error count) in that cycle, then the state is IDLE on the next cycle.
- Simultaneous frame end and start is impossible given the 2-flop spacing; no special handling.
- Write and read of the same register in one frame: the read returns the post-write value.
- Reset asserted mid-frame: immediate return to reset values. If ss is still low at release, the block waits in IDLE for a full high->low edge; the rest of that frame is ignored.
- Pointer arithmetic: ptr is ADDR_W bits and wraps at NUM_REGS-1 -> 0 (mod NUM_REGS, not mod 2**ADDR_W).

Optional Feature:
- Macro: SPI_REG_AUTOINC_EN.
- Defined: after each data byte in DATA, ptr advances (wrapping as above), giving burst reads and writes.
- Undefined: ptr stays at the command address. Repeated data bytes rewrite, or re-read, the same register.
- err_cnt, DROP and the frame rules are identical in both builds.

Test Plan:
- Write: frame {0x83, 0x5C}, NUM_REGS=8 -> reg3=0x5C, one wr_strobe with wr_addr=3; tx_byte returns to 0xA5 after ss rises; all other regs 0.
- Read: preload reg5=0x3E; frame {0x05, 0x00} -> tx_byte=0x3E after the command byte's rx_valid, before the next tx_req; regs unchanged; no wr_strobe.
- Illegal address: frame {0x8A, 0xFF} -> err_cnt=1, no write, tx_byte=0x00 in DROP. 256 such frames -> err_cnt stays at 255.
- Burst, macro defined: frame {0x86, 0x11, 0x22, 0x33} -> reg6=0x11, reg7=0x22, reg0=0x33 (wrap). Same frame with macro undefined -> reg6=0x33, three strobes.
- Reset mid-frame: after command 0x81, pulse rst_n low while ss stays low, then send 0x77 -> all regs 0, no write. A new frame then operates normally.
- Edge collision: rx_valid of data 0x99 in the same cycle as the ss_s rising edge (write frame to addr 2) -> reg2=0x99, state IDLE next cycle.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: decodes slave-select framed SPI bytes into register reads/writes.
// Build option: define SPI_REG_AUTOINC_EN to advance the pointer per data byte.
module spi_reg_ctrl #(
    parameter int unsigned NUM_REGS  = 8,
    parameter int unsigned ADDR_W    = 3,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ss,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    input  logic                  tx_req,
    output logic [7:0]            tx_byte,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic                  wr_strobe,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [7:0]            err_cnt
);

`ifdef SPI_REG_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    localparam logic [7:0]        NREG8 = 8'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        DROP
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                wr_mode_q, wr_mode_d;
    logic [7:0]          tx_q, tx_d;
    logic                strobe_q, strobe_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [7:0]          err_q, err_d;
    logic [7:0]          regs_q [NUM_REGS];
    logic                we;

    logic                ss_q1, ss_s_q, ss_prev_q;
    logic [1:0]          fill_q;
    logic                ss_fall, ss_rise;

    logic [ADDR_W-1:0]   cmd_addr;
    logic                cmd_bad;
    logic [ADDR_W-1:0]   ptr_wrap;
    logic [ADDR_W-1:0]   ptr_nxt;

    // tx_req needs no action: tx_byte is always kept stable ahead of it
    logic                unused_tx_req;
    assign unused_tx_req = tx_req;

    // Synchronise ss; prev only holds real samples once the chain is refilled,
    // so a low ss at reset release is not mistaken for a frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_q1     <= 1'b1;
            ss_s_q    <= 1'b1;
            fill_q    <= 2'b00;
            ss_prev_q <= 1'b0;
        end else begin
            ss_q1     <= ss;
            ss_s_q    <= ss_q1;
            fill_q    <= {fill_q[0], 1'b1};
            ss_prev_q <= ss_s_q & fill_q[1];
        end
    end

    assign ss_fall  = ss_prev_q & ~ss_s_q;
    assign ss_rise  = ~ss_prev_q & ss_s_q;

    assign cmd_addr = rx_byte[ADDR_W-1:0];
    assign cmd_bad  = ({1'b0, rx_byte[6:0]} >= NREG8);
    assign ptr_wrap = (ptr_q == LAST) ? '0 : ptr_q + ADDR_W'(1);
    assign ptr_nxt  = AUTOINC ? ptr_wrap : ptr_q;

    // Frame state machine: next state, pointer, tx byte and write enable
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wr_mode_d = wr_mode_q;
        tx_d      = tx_q;
        strobe_d  = 1'b0;
        waddr_d   = waddr_q;
        err_d     = err_q;
        we        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = CMD;
                    tx_d    = SYNC_BYTE;
                end
            end
            CMD: begin
                if (rx_valid) begin
                    if (cmd_bad) begin
                        state_d = DROP;
                        tx_d    = 8'h00;
                        if (err_q != 8'hFF) begin
                            err_d = err_q + 8'd1;
                        end
                    end else begin
                        state_d   = DATA;
                        ptr_d     = cmd_addr;
                        wr_mode_d = rx_byte[7];
                        if (!rx_byte[7]) begin
                            tx_d = regs_q[cmd_addr];
                        end
                    end
                end
            end
            DATA: begin
                if (rx_valid) begin
                    ptr_d = ptr_nxt;
                    if (wr_mode_q) begin
                        we       = 1'b1;
                        strobe_d = 1'b1;
                        waddr_d  = ptr_q;
                    end else begin
                        tx_d = regs_q[ptr_nxt];
                    end
                end
            end
            DROP: begin
                tx_d = 8'h00;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Frame end wins over everything but lets the last byte complete
        if ((state_q != IDLE) && ss_rise) begin
            state_d = IDLE;
            tx_d    = SYNC_BYTE;
        end
    end

    // Control and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            wr_mode_q <= 1'b0;
            tx_q      <= SYNC_BYTE;
            strobe_q  <= 1'b0;
            waddr_q   <= '0;
            err_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_mode_q <= wr_mode_d;
            tx_q      <= tx_d;
            strobe_q  <= strobe_d;
            waddr_q   <= waddr_d;
            err_q     <= err_d;
        end
    end

    // Register bank, written at the pointer on each data byte of a write frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (we) begin
            regs_q[ptr_q] <= rx_byte;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs_q[g];
    end

    assign tx_byte   = tx_q;
    assign wr_strobe = strobe_q;
    assign wr_addr   = waddr_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: randomized frames against a register-array model.
// Expected tx bytes and writes are queued and checked by a monitor.
module tb_spi_reg_ctrl;

    localparam int         N    = 8;
    localparam int         AW   = 3;
    localparam logic [7:0] SYNC = 8'hA5;

`ifdef SPI_REG_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic           clk      = 1'b0;
    logic           rst_n    = 1'b0;
    logic           ss       = 1'b1;
    logic [7:0]     rx_byte  = 8'h00;
    logic           rx_valid = 1'b0;
    logic           tx_req   = 1'b0;
    logic [7:0]     tx_byte;
    logic [N*8-1:0] regs_flat;
    logic           wr_strobe;
    logic [AW-1:0]  wr_addr;
    logic [7:0]     err_cnt;

    spi_reg_ctrl #(
        .NUM_REGS (N),
        .ADDR_W   (AW),
        .SYNC_BYTE(SYNC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ss       (ss),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .tx_req   (tx_req),
        .tx_byte  (tx_byte),
        .regs_flat(regs_flat),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         chk;
        logic [7:0] v;
    } tx_exp_t;

    typedef struct {
        int         a;
        logic [7:0] d;
    } wr_exp_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] mem [N];
    int         err_m = 0;
    tx_exp_t    txq[$];
    wr_exp_t    wrq[$];
    tx_exp_t    te;
    wr_exp_t    we_e;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_flat();
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < N; i++) f[8*i +: 8] = mem[i];
        return f;
    endfunction

    // Monitor: every tx_req and every wr_strobe consumes one expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_req) begin
                if (txq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_req_unplanned: got tx_byte %0h, expected no request", tx_byte);
                end else begin
                    te = txq.pop_front();
                    if (te.chk) check("tx_byte", 64'(tx_byte), 64'(te.v));
                end
            end
            if (wr_strobe) begin
                if (wrq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL wr_strobe_spurious: got strobe at addr %0d, expected none", wr_addr);
                end else begin
                    we_e = wrq.pop_front();
                    check("wr_addr", 64'(wr_addr), 64'(we_e.a));
                    check("wr_data", 64'(regs_flat[8*we_e.a +: 8]), 64'(we_e.d));
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer(logic [7:0] b, tx_exp_t e);
        txq.push_back(e);
        tx_req = 1'b1;
        tick(1);
        tx_req = 1'b0;
        tick(int'($urandom_range(1, 3)));
        rx_byte  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
        tick(int'($urandom_range(1, 3)));
    endtask

    task automatic end_checks(string nm);
        check({nm, "_tx_sync"}, 64'(tx_byte), 64'(SYNC));
        check({nm, "_regs"}, regs_flat, model_flat());
        check({nm, "_err"}, 64'(err_cnt), 64'(err_m));
        check({nm, "_wr_pending"}, 64'(wrq.size()), 64'd0);
    endtask

    // One frame: command then data; collide puts the last byte on the ss edge
    task automatic run_frame(logic [7:0] cmd, logic [7:0] data[$], bit collide);
        int      a   = int'(cmd[6:0]);
        bit      wr  = cmd[7];
        bit      bad = (a >= N);
        int      p   = a;
        tx_exp_t e;
        ss = 1'b0;
        tick(4);
        xfer(cmd, '{1'b1, SYNC});
        if (bad && err_m < 255) err_m++;
        foreach (data[k]) begin
            if (bad)     e = '{1'b1, 8'h00};
            else if (wr) e = '{1'b0, 8'h00};
            else         e = '{1'b1, mem[p]};
            if (!bad && wr) begin
                mem[p] = data[k];
                wrq.push_back('{p, data[k]});
            end
            if (!bad && AUTOINC) p = (p + 1) % N;
            if (collide && k == data.size() - 1) begin
                txq.push_back(e);
                tx_req = 1'b1;
                tick(1);
                tx_req = 1'b0;
                tick(1);
                ss = 1'b1;
                tick(2);
                rx_byte  = data[k];
                rx_valid = 1'b1;
                tick(1);
                rx_valid = 1'b0;
                tick(1);
                // block is idle now, so a stray byte must be ignored
                rx_byte  = 8'h55;
                rx_valid = 1'b1;
                tick(1);
                rx_valid = 1'b0;
                tick(3);
            end else begin
                xfer(data[k], e);
            end
        end
        if (!collide) begin
            ss = 1'b1;
            tick(4);
        end
        end_checks(collide ? "collide" : "frame");
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d[$];
        for (int i = 0; i < N; i++) mem[i] = 8'h00;
        tick(3);
        check("rst_tx", 64'(tx_byte), 64'(SYNC));
        check("rst_regs", regs_flat, 64'd0);
        check("rst_err", 64'(err_cnt), 64'd0);
        check("rst_strobe", 64'(wr_strobe), 64'd0);
        check("rst_waddr", 64'(wr_addr), 64'd0);
        rst_n = 1'b1;
        tick(5);

        d = {8'h5C};
        run_frame(8'h83, d, 1'b0);
        d = {8'h3E};
        run_frame(8'h85, d, 1'b0);
        d = {8'h00};
        run_frame(8'h05, d, 1'b0);
        d = {8'hFF};
        run_frame(8'h8A, d, 1'b0);
        d = {8'h11, 8'h22, 8'h33};
        run_frame(8'h86, d, 1'b0);
        d = {8'h00, 8'h00, 8'h00};
        run_frame(8'h06, d, 1'b0);
        d = {8'h99};
        run_frame(8'h82, d, 1'b1);

        for (int f = 0; f < 40; f++) begin
            logic [7:0] cmd;
            cmd = {1'($urandom), 7'($urandom_range(0, 11))};
            d.delete();
            repeat ($urandom_range(1, 4)) d.push_back(8'($urandom));
            run_frame(cmd, d, ($urandom_range(0, 4) == 0));
        end

        d = {8'hFF};
        for (int f = 0; f < 256; f++) begin
            run_frame(8'($urandom_range(8, 127)), d, 1'b0);
        end
        check("err_saturated", 64'(err_cnt), 64'd255);

        ss = 1'b0;
        tick(4);
        xfer(8'h81, '{1'b1, SYNC});
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) mem[i] = 8'h00;
        err_m = 0;
        tick(1);
        check("midrst_regs", regs_flat, 64'd0);
        check("midrst_err", 64'(err_cnt), 64'd0);
        check("midrst_tx", 64'(tx_byte), 64'(SYNC));
        tick(3);
        xfer(8'h77, '{1'b1, SYNC});
        xfer(8'h77, '{1'b1, SYNC});
        ss = 1'b1;
        tick(4);
        end_checks("midrst");
        d = {8'h42, 8'h43};
        run_frame(8'h81, d, 1'b0);
        d = {8'h00};
        run_frame(8'h01, d, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
